// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle adder/subtractor that adds CHUNK bits per clock,
// rippling the carry between chunks, and reports sum, carry-out and signed
// overflow with a one-cycle done pulse.
module seq_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SH_W  = $clog2(WIDTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [SH_W-1:0]  sh_c;
  logic [WIDTH-1:0] a_sh_c, b_sh_c, mask_c, shadow_nx_c;
  logic [CHUNK-1:0] ca_c, cb_c, cs_c;
  logic             cc_c, c_msb_c, last_c;

  // Chunk slice selection, chunk add and carry into the chunk MSB.
  always_comb begin
    sh_c        = SH_W'(cnt_q) * SH_W'(CHUNK);
    a_sh_c      = op_a_q >> sh_c;
    b_sh_c      = op_b_q >> sh_c;
    ca_c        = a_sh_c[CHUNK-1:0];
    cb_c        = b_sh_c[CHUNK-1:0];
    {cc_c, cs_c} = (CHUNK+1)'(ca_c) + (CHUNK+1)'(cb_c) + (CHUNK+1)'(carry_q);
    // Carry into a bit is recovered as sum ^ a ^ b at that bit.
    c_msb_c     = cs_c[CHUNK-1] ^ ca_c[CHUNK-1] ^ cb_c[CHUNK-1];
    mask_c      = WIDTH'({CHUNK{1'b1}}) << sh_c;
    shadow_nx_c = (shadow_q & ~mask_c) | (WIDTH'(cs_c) << sh_c);
    last_c      = (cnt_q == CNT_W'(N - 1));
  end

  // Next-state and registered-output logic for IDLE -> BUSY -> DONE.
  // A restart from DONE is taken on the edge that leaves DONE.
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    sum_d    = sum_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          op_a_d   = a;
          op_b_d   = sub ? ~b : b;
          carry_d  = sub;
          cnt_d    = '0;
          shadow_d = '0;
          state_d  = ST_BUSY;
          busy_d   = 1'b1;
        end
      end
      ST_BUSY: begin
        carry_d  = cc_c;
        shadow_d = shadow_nx_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_c) begin
          cnt_d   = '0;
          sum_d   = shadow_nx_c;
          c_out_d = cc_c;
          ovf_d   = cc_c ^ c_msb_c;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      shadow_q <= '0;
      sum_q    <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      sum_q    <= sum_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Directed bench for seq_addsub with WIDTH=16, CHUNK=4.
module tb_seq_addsub;

  localparam int unsigned W = 16;
  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst, start, sub;
  logic [W-1:0] a, b;
  logic         busy, done, c_out, ovf;
  logic [W-1:0] sum;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] held_sum;
  logic         held_c, held_v;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         c;
    logic         v;
  } vec_t;

  vec_t vecs[11];

  seq_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_sum_held"}, 32'(sum), 32'(held_sum));
    chk({tag, "_c_held"}, 32'(c_out), 32'(held_c));
    chk({tag, "_v_held"}, 32'(ovf), 32'(held_v));
  endtask

  task automatic chk_result(input string tag, input logic [W-1:0] es, input logic ec, input logic ev);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(c_out), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(ev));
    held_sum = es;
    held_c   = ec;
    held_v   = ev;
  endtask

  // One complete operation; checks busy window, held results and final result.
  task automatic do_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic isub, input logic [W-1:0] es, input logic ec, input logic ev);
    @(negedge clk);
    a = ia; b = ib; sub = isub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~ia; b = ~ib; sub = ~isub;
    for (int i = 0; i < int'(N); i++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_no_done"}, 32'(done), 32'd0);
      chk_held(tag);
      @(negedge clk);
    end
    chk_result(tag, es, ec, ev);
  endtask

  initial begin
    vecs[0]  = '{16'h000B, 16'h000D, 1'b0, 16'h0018, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3]  = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4]  = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5]  = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[8]  = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[10] = '{16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    held_sum = '0; held_c = 1'b0; held_v = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(c_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    // Table of single operations.
    for (int i = 0; i < 11; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
            vecs[i].sum, vecs[i].c, vecs[i].v);
    end

    // Back-to-back with start held: DONE goes straight to BUSY.
    @(negedge clk);
    a = 16'h0001; b = 16'h0002; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 16'h0010;
    for (int i = 0; i < int'(N); i++) begin
      chk("b2b1_busy", 32'(busy), 32'd1);
      chk("b2b1_excl", 32'(busy & done), 32'd0);
      chk_held("b2b1");
      @(negedge clk);
    end
    chk_result("b2b1", 16'h0003, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      chk("b2b2_busy", 32'(busy), 32'd1);
      chk("b2b2_excl", 32'(busy & done), 32'd0);
      chk("b2b2_sum_held", 32'(sum), 32'h0003);
      @(negedge clk);
    end
    chk_result("b2b2", 16'h0012, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    chk("b2b_idle_done", 32'(done), 32'd0);

    // Start pulse during BUSY is ignored.
    @(negedge clk);
    a = 16'h0003; b = 16'h0004; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy0", 32'(busy), 32'd1);
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; start = 1'b1;
    chk("ign_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    for (int i = 2; i < int'(N); i++) begin
      chk("ign_busy", 32'(busy), 32'd1);
      chk("ign_no_done", 32'(done), 32'd0);
      @(negedge clk);
      if (i == 2) ;
    end
    chk_result("ign", 16'h0007, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ign_after_busy", 32'(busy), 32'd0);
      chk("ign_after_done", 32'(done), 32'd0);
      chk("ign_after_sum", 32'(sum), 32'h0007);
    end

    // Reset in the third BUSY cycle abandons the operation.
    @(negedge clk);
    a = 16'h00FF; b = 16'h0001; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rmid_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_done", 32'(done), 32'd0);
    chk("rmid_sum", 32'(sum), 32'd0);
    chk("rmid_cout", 32'(c_out), 32'd0);
    chk("rmid_ovf", 32'(ovf), 32'd0);
    held_sum = '0; held_c = 1'b0; held_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rmid_no_done", 32'(done), 32'd0);
      chk("rmid_idle", 32'(busy), 32'd0);
    end
    do_op("rfresh", 16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
